// File: rtl/gcd_dest_m.sv
// Equivalence miter of two independently built subtract-and-swap GCD engines.
// E1 decides with a magnitude compare, E2 with the borrow of a (W+1)-bit difference.
//
// state | meaning
// IDLE  | after reset, registers hold until start
// RUN   | one subtract-or-swap step per cycle until B reaches zero
// DONE  | A holds gcd, B holds zero, registers hold until start
module gcd_dest_m #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] Ain,
  input  logic [W-1:0] Bin,
  output logic         equiv,
  output logic [W-1:0] ao1,
  output logic [W-1:0] bo1,
  output logic [W-1:0] ao2,
  output logic [W-1:0] bo2
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t       st1, st1_nxt;
  logic [W-1:0] a1, b1, a1_nxt, b1_nxt;

  state_t       st2, st2_nxt;
  logic [W-1:0] a2, b2, a2_nxt, b2_nxt;
  logic [W:0]   diff2;

  always_ff @(posedge clk) begin
    if (reset) begin
      st1 <= IDLE;
      a1  <= '0;
      b1  <= '0;
    end else begin
      st1 <= st1_nxt;
      a1  <= a1_nxt;
      b1  <= b1_nxt;
    end
  end

  always_comb begin
    st1_nxt = st1;
    a1_nxt  = a1;
    b1_nxt  = b1;
    if (start) begin
      st1_nxt = RUN;
      a1_nxt  = Ain;
      b1_nxt  = Bin;
    end else if (st1 == RUN) begin
      if (b1 == '0) begin
        st1_nxt = DONE;
      end else if (a1 < b1) begin
        a1_nxt = b1;
        b1_nxt = a1;
      end else begin
        a1_nxt = a1 - b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st2 <= IDLE;
      a2  <= '0;
      b2  <= '0;
    end else begin
      st2 <= st2_nxt;
      a2  <= a2_nxt;
      b2  <= b2_nxt;
    end
  end

  // Borrow bit of the extended difference replaces E1's comparator.
  assign diff2 = {1'b0, a2} - {1'b0, b2};

  always_comb begin
    st2_nxt = st2;
    a2_nxt  = a2;
    b2_nxt  = b2;
    if (start) begin
      st2_nxt = RUN;
      a2_nxt  = Ain;
      b2_nxt  = Bin;
    end else if (st2 == RUN) begin
      if (diff2[W]) begin
        a2_nxt = b2;
        b2_nxt = a2;
      end else if (b2 == '0) begin
        st2_nxt = DONE;
      end else begin
        a2_nxt = diff2[W-1:0];
      end
    end
  end

  assign ao1   = a1;
  assign bo1   = b1;
  assign ao2   = a2;
  assign bo2   = b2;
  assign equiv = (ao1 == ao2) && (bo1 == bo2);

endmodule

// File: tb/tb_gcd_dest_m.sv
// Directed and randomized checks of the gcd_dest_m miter against hand-computed
// register sequences and a reference Euclid gcd.
module tb_gcd_dest_m;
  localparam int W = 6;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] Ain = '0;
  logic [W-1:0] Bin = '0;
  logic         equiv;
  logic [W-1:0] ao1, bo1, ao2, bo2;

  int n_tests = 0;
  int n_fail  = 0;

  gcd_dest_m #(.W(W)) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .Ain  (Ain),
    .Bin  (Bin),
    .equiv(equiv),
    .ao1  (ao1),
    .bo1  (bo1),
    .ao2  (ao2),
    .bo2  (bo2)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int ref_gcd(input int a, input int b);
    int x = a;
    int y = b;
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic test_reset();
    logic [W-1:0] ea = '0;
    logic [W-1:0] eb = '0;
    reset = 1'b1;
    start = 1'b1;
    Ain   = 6'd7;
    Bin   = 6'd3;
    tick();
    n_tests++;
    if ({ao1, bo1, ao2, bo2, equiv} !== {ea, eb, ea, eb, 1'b1}) begin
      n_fail++;
      $display("FAIL reset: got a1=%0d b1=%0d a2=%0d b2=%0d eq=%b, want a=%0d b=%0d eq=1",
               ao1, bo1, ao2, bo2, equiv, ea, eb);
    end
    reset = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_load_42();
    logic [W-1:0] ea = 6'd42;
    logic [W-1:0] eb = 6'd0;
    start = 1'b1;
    Ain   = 6'd42;
    Bin   = 6'd0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if ({ao1, bo1, ao2, bo2, equiv} !== {ea, eb, ea, eb, 1'b1}) begin
        n_fail++;
        $display("FAIL load_42[%0d]: got a1=%0d b1=%0d a2=%0d b2=%0d eq=%b, want a=%0d b=%0d eq=1",
                 i, ao1, bo1, ao2, bo2, equiv, ea, eb);
      end
      if (i < 3) tick();
    end
  endtask

  task automatic test_seq_12_8();
    int exp_a[7] = '{12, 4, 8, 4, 0, 4, 4};
    int exp_b[7] = '{8, 8, 4, 4, 4, 0, 0};
    logic [W-1:0] ea, eb;
    start = 1'b1;
    Ain   = 6'd12;
    Bin   = 6'd8;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      ea = W'(exp_a[i]);
      eb = W'(exp_b[i]);
      n_tests++;
      if ({ao1, bo1, ao2, bo2, equiv} !== {ea, eb, ea, eb, 1'b1}) begin
        n_fail++;
        $display("FAIL seq_12_8[%0d]: got a1=%0d b1=%0d a2=%0d b2=%0d eq=%b, want a=%0d b=%0d eq=1",
                 i, ao1, bo1, ao2, bo2, equiv, ea, eb);
      end
      if (i < 6) tick();
    end
  endtask

  task automatic test_zero_operands();
    int exp_a[8] = '{0, 5, 5, 5, 0, 0, 0, 0};
    int exp_b[8] = '{5, 0, 0, 0, 0, 0, 0, 0};
    logic [W-1:0] ea, eb;
    for (int i = 0; i < 8; i++) begin
      if (i == 0) begin
        start = 1'b1; Ain = 6'd0; Bin = 6'd5;
      end else if (i == 4) begin
        start = 1'b1; Ain = 6'd0; Bin = 6'd0;
      end
      tick();
      start = 1'b0;
      ea = W'(exp_a[i]);
      eb = W'(exp_b[i]);
      n_tests++;
      if ({ao1, bo1, ao2, bo2, equiv} !== {ea, eb, ea, eb, 1'b1}) begin
        n_fail++;
        $display("FAIL zero_ops[%0d]: got a1=%0d b1=%0d a2=%0d b2=%0d eq=%b, want a=%0d b=%0d eq=1",
                 i, ao1, bo1, ao2, bo2, equiv, ea, eb);
      end
    end
  endtask

  task automatic test_count_63_1();
    logic [W-1:0] ea, eb;
    start = 1'b1;
    Ain   = 6'd63;
    Bin   = 6'd1;
    tick();
    start = 1'b0;
    // 64 states (63..0, 1), then the swap, then one held edge.
    for (int k = 63; k >= -2; k--) begin
      if (k >= 0) begin
        ea = W'(k);
        eb = 6'd1;
      end else begin
        ea = 6'd1;
        eb = 6'd0;
      end
      n_tests++;
      if ({ao1, bo1, ao2, bo2, equiv} !== {ea, eb, ea, eb, 1'b1}) begin
        n_fail++;
        $display("FAIL count_63_1[%0d]: got a1=%0d b1=%0d a2=%0d b2=%0d eq=%b, want a=%0d b=%0d eq=1",
                 k, ao1, bo1, ao2, bo2, equiv, ea, eb);
      end
      if (k > -2) tick();
    end
  endtask

  task automatic test_reload_and_reset();
    int exp_a[12] = '{12, 4, 9, 3, 6, 3, 0, 3, 3, 12, 4, 0};
    int exp_b[12] = '{8, 8, 6, 6, 3, 3, 3, 0, 0, 8, 8, 0};
    logic [W-1:0] ea, eb;
    for (int i = 0; i < 13; i++) begin
      start = 1'b0;
      reset = 1'b0;
      if (i == 0 || i == 9) begin
        start = 1'b1; Ain = 6'd12; Bin = 6'd8;
      end else if (i == 2) begin
        start = 1'b1; Ain = 6'd9; Bin = 6'd6;
      end else if (i == 11) begin
        reset = 1'b1;
      end
      tick();
      if (i == 12) begin
        ea = '0;
        eb = '0;
      end else begin
        ea = W'(exp_a[i]);
        eb = W'(exp_b[i]);
      end
      n_tests++;
      if ({ao1, bo1, ao2, bo2, equiv} !== {ea, eb, ea, eb, 1'b1}) begin
        n_fail++;
        $display("FAIL reload_reset[%0d]: got a1=%0d b1=%0d a2=%0d b2=%0d eq=%b, want a=%0d b=%0d eq=1",
                 i, ao1, bo1, ao2, bo2, equiv, ea, eb);
      end
    end
    start = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_random();
    int ra, rb, g;
    bit done, aborted;
    for (int t = 0; t < 40; t++) begin
      ra = int'($urandom_range(0, 63));
      rb = int'($urandom_range(0, 63));
      start = 1'b1;
      Ain   = W'(ra);
      Bin   = W'(rb);
      tick();
      start = 1'b0;
      n_tests++;
      if ({ao1, bo1, ao2, bo2} !== {W'(ra), W'(rb), W'(ra), W'(rb)}) begin
        n_fail++;
        $display("FAIL rand_load[%0d]: got a1=%0d b1=%0d a2=%0d b2=%0d, want a=%0d b=%0d",
                 t, ao1, bo1, ao2, bo2, ra, rb);
      end
      done    = 1'b0;
      aborted = 1'b0;
      for (int c = 0; c < 150 && !done && !aborted; c++) begin
        if ($urandom_range(0, 39) == 0) begin
          reset = 1'b1;
          tick();
          reset = 1'b0;
          aborted = 1'b1;
          n_tests++;
          if ({ao1, bo1, ao2, bo2, equiv} !== {{(4*W){1'b0}}, 1'b1}) begin
            n_fail++;
            $display("FAIL rand_reset[%0d]: got a1=%0d b1=%0d a2=%0d b2=%0d eq=%b, want all 0 eq=1",
                     t, ao1, bo1, ao2, bo2, equiv);
          end
        end else begin
          tick();
          n_tests++;
          if (equiv !== 1'b1) begin
            n_fail++;
            $display("FAIL rand_equiv[%0d]: got eq=%b a1=%0d b1=%0d a2=%0d b2=%0d, want eq=1",
                     t, equiv, ao1, bo1, ao2, bo2);
          end
          if (bo1 == '0) done = 1'b1;
        end
      end
      if (!aborted) begin
        g = ref_gcd(ra, rb);
        n_tests++;
        if (!done) begin
          n_fail++;
          $display("FAIL rand_timeout[%0d]: got b1=%0d after 150 cycles, want 0", t, bo1);
        end else if ({ao1, ao2, bo2} !== {W'(g), W'(g), {W{1'b0}}}) begin
          n_fail++;
          $display("FAIL rand_gcd[%0d]: got a1=%0d a2=%0d b2=%0d, want gcd(%0d,%0d)=%0d b=0",
                   t, ao1, ao2, bo2, ra, rb, g);
        end
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_load_42();
    test_seq_12_8();
    test_zero_operands();
    test_count_63_1();
    test_reload_and_reset();
    test_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
